// File: rtl/tiny45_mem_ctrl.sv
// Load/store stage behind the nibble-serial core: one 32-bit bus transaction per request,
// load data streamed back as nibbles. Optional macro TINY45_MEMCTL_ALIGN_CHECK_EN adds misalign_err.
module tiny45_mem_ctrl #(
    parameter int ADDR_BITS = 28
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [2:0]           counter,
    input  logic                 address_ready,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic [2:0]           mem_op,
    input  logic [ADDR_BITS-1:0] addr_in,
    input  logic [3:0]           store_nibble,
    output logic [3:0]           load_nibble,
    output logic                 load_data_ready,
    output logic                 busy,
    output logic                 overrun,
    output logic [ADDR_BITS-3:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata
`ifdef TINY45_MEMCTL_ALIGN_CHECK_EN
    ,
    output logic                 misalign_err
`endif
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, ALIGN, STREAM} state_t;

    state_t      state;
    logic [31:0] sdata;
    logic [31:0] store_word;
    logic [31:0] rbuf;
    logic [31:0] load_word;
    logic [31:0] wdata_next;
    logic [3:0]  wstrb_next;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [1:0]  off;
    logic        request;
    logic        misaligned;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        store_word = {store_nibble, sdata[31:4]};
        off        = addr_in[1:0];
        request    = address_ready && (is_load || is_store);
        misaligned = 1'b0;
`ifdef TINY45_MEMCTL_ALIGN_CHECK_EN
        misaligned = (mem_op[1:0] == 2'b01 && off[0]) || (mem_op[1:0] == 2'b10 && off != 2'b00);
`endif
        wstrb_next = 4'b1111;
        wdata_next = store_word;
        case (mem_op[1:0])
            2'b00: begin
                wstrb_next = 4'b0001 << off;
                wdata_next = {4{store_word[7:0]}};
            end
            2'b01: begin
                wstrb_next = 4'b0011 << {off[1], 1'b0};
                wdata_next = {2{store_word[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select and extension use the op/offset captured with the request.
    always_comb begin
        lane_byte = mem_rdata[{off_q, 3'b000} +: 8];
        lane_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q[1:0])
            2'b00:   load_word = {{24{~op_q[2] & lane_byte[7]}}, lane_byte};
            2'b01:   load_word = {{16{~op_q[2] & lane_half[15]}}, lane_half};
            default: load_word = mem_rdata;
        endcase
    end

    always_comb begin
        load_nibble = load_data_ready ? rbuf[{counter, 2'b00} +: 4] : 4'h0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sdata <= '0;
        end else begin
            sdata <= store_word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            busy            <= 1'b0;
            load_data_ready <= 1'b0;
            overrun         <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_wstrb       <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            rbuf            <= '0;
            op_q            <= '0;
            off_q           <= '0;
`ifdef TINY45_MEMCTL_ALIGN_CHECK_EN
            misalign_err    <= 1'b0;
`endif
        end else begin
            overrun <= request && (state != IDLE);
`ifdef TINY45_MEMCTL_ALIGN_CHECK_EN
            misalign_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (request) begin
                        mem_addr <= addr_in[ADDR_BITS-1:2];
                        op_q     <= mem_op;
                        off_q    <= off;
                        if (misaligned) begin
`ifdef TINY45_MEMCTL_ALIGN_CHECK_EN
                            misalign_err <= 1'b1;
`endif
                            // A rejected load still returns a zero word so the core completes.
                            if (is_load) begin
                                rbuf  <= '0;
                                state <= ALIGN;
                                busy  <= 1'b1;
                            end
                        end else if (is_load) begin
                            mem_read <= 1'b1;
                            state    <= READ;
                            busy     <= 1'b1;
                        end else begin
                            mem_write <= 1'b1;
                            mem_wdata <= wdata_next;
                            mem_wstrb <= wstrb_next;
                            state     <= WRITE;
                            busy      <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (mem_ready) begin
                        rbuf     <= load_word;
                        mem_read <= 1'b0;
                        if (counter == 3'd7) begin
                            state           <= STREAM;
                            load_data_ready <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                ALIGN: begin
                    if (counter == 3'd7) begin
                        state           <= STREAM;
                        load_data_ready <= 1'b1;
                    end
                end
                STREAM: begin
                    if (counter == 3'd7) begin
                        state           <= IDLE;
                        load_data_ready <= 1'b0;
                        busy            <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tiny45_mem_ctrl.sv
// Self-checking bench for tiny45_mem_ctrl: a timeline-based transaction model checked every cycle,
// plus literal expectations for directed loads/stores, overrun and reset.
module tb_tiny45_mem_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [2:0]  counter = '0;
    logic        address_ready = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  mem_op = '0;
    logic [27:0] addr_in = '0;
    logic [3:0]  store_nibble = '0;
    logic [3:0]  load_nibble;
    logic        load_data_ready;
    logic        busy;
    logic        overrun;
    logic [25:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_read;
    logic        mem_write;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef TINY45_MEMCTL_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    tiny45_mem_ctrl dut (
        .clk(clk), .rstn(rstn), .counter(counter), .address_ready(address_ready),
        .is_load(is_load), .is_store(is_store), .mem_op(mem_op), .addr_in(addr_in),
        .store_nibble(store_nibble), .load_nibble(load_nibble),
        .load_data_ready(load_data_ready), .busy(busy), .overrun(overrun),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
`ifdef TINY45_MEMCTL_ALIGN_CHECK_EN
        , .misalign_err(misalign_err)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // The core's sub-cycle counter free-runs; cycle k has counter == k % 8.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        counter = cyc[2:0];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Bus responder: completes a request once it has been pending longer than ready_delay cycles.
    int ready_delay = 0;
    bit tie_ready = 1'b0;
    int wait_n = 0;
    always @(posedge clk) begin
        #2;
        if (mem_read || mem_write) wait_n++;
        else wait_n = 0;
        mem_ready = tie_ready || ((mem_read || mem_write) && wait_n > ready_delay);
    end

    function automatic logic [3:0] f_wstrb(input logic [2:0] op, input logic [1:0] o);
        case (op[1:0])
            2'b00:   return 4'b0001 << o;
            2'b01:   return o[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] op, input logic [31:0] d);
        case (op[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] op, input logic [1:0] o,
                                           input logic [31:0] r);
        logic [31:0] v;
        case (op[1:0])
            2'b00: begin
                v = (r >> (8 * o)) & 32'hFF;
                if (!op[2] && v[7]) v = v | 32'hFFFFFF00;
            end
            2'b01: begin
                v = (r >> (o[1] ? 16 : 0)) & 32'hFFFF;
                if (!op[2] && v[15]) v = v | 32'hFFFF0000;
            end
            default: v = r;
        endcase
        return v;
    endfunction

    function automatic bit f_mis(input logic [2:0] op, input logic [1:0] o);
`ifdef TINY45_MEMCTL_ALIGN_CHECK_EN
        return (op[1:0] == 2'b01 && o[0]) || (op[1:0] == 2'b10 && o != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Transaction model: accepted at cycle m_a, bus done at m_d, stream window m_s..m_s+7.
    logic [31:0] drv_data = '0;
    bit          m_act = 0, m_load = 0, m_bus = 0, exp_ovr = 0, exp_mis = 0;
    int          m_a = 0, m_d = -1, m_s = 0;
    logic [31:0] m_word = '0, m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    logic [25:0] m_addr = '0;
    logic [2:0]  m_op = '0;
    logic [1:0]  m_off = '0;
    bit          bus_e, ldr_e, busy_e;
    int          wr_n = 0, rd_n = 0, ovr_n = 0, mis_n = 0, stream_n = 0, first_cnt = -1;
    logic [31:0] last_wdata = '0, stream_word = '0;
    logic [3:0]  last_wstrb = '0;
    logic [25:0] last_addr = '0;

    always @(negedge clk) begin
        if (!rstn) begin
            check("reset_ctrl", {load_nibble, load_data_ready, busy, overrun, mem_read,
                                 mem_write, mem_wstrb}, 32'h0);
            check("reset_addr", mem_addr, 32'h0);
            check("reset_wdata", mem_wdata, 32'h0);
            m_act = 0;
            exp_ovr = 0;
            exp_mis = 0;
        end else begin
            bus_e  = m_act && m_bus && cyc > m_a && m_d < 0;
            ldr_e  = m_act && m_load && m_d >= 0 && cyc >= m_s && cyc <= m_s + 7;
            busy_e = m_act && cyc > m_a;
            check("mem_read", mem_read, bus_e && m_load);
            check("mem_write", mem_write, bus_e && !m_load);
            check("busy", busy, busy_e);
            check("load_data_ready", load_data_ready, ldr_e);
            check("overrun", overrun, exp_ovr);
`ifdef TINY45_MEMCTL_ALIGN_CHECK_EN
            check("misalign_err", misalign_err, exp_mis);
            if (misalign_err) mis_n++;
`endif
            if (bus_e) check("mem_addr", mem_addr, m_addr);
            if (bus_e && !m_load) begin
                check("mem_wdata", mem_wdata, m_wdata);
                check("mem_wstrb", mem_wstrb, m_wstrb);
            end
            if (ldr_e) check("load_nibble", load_nibble, m_word[(cyc % 8) * 4 +: 4]);

            if (mem_write) begin
                wr_n++;
                last_wdata = mem_wdata;
                last_wstrb = mem_wstrb;
                last_addr  = mem_addr;
            end
            if (mem_read) rd_n++;
            if (overrun) ovr_n++;
            if (load_data_ready) begin
                if (first_cnt < 0) first_cnt = counter;
                stream_word[counter * 4 +: 4] = load_nibble;
                stream_n++;
            end

            if (bus_e && mem_ready) begin
                m_d = cyc;
                if (m_load) begin
                    m_word = f_load(m_op, m_off, mem_rdata);
                    m_s = cyc + 8 - (cyc % 8);
                end
            end
            if (m_act && !m_load && m_d >= 0) m_act = 0;
            if (m_act && m_load && m_d >= 0 && cyc == m_s + 7) m_act = 0;

            exp_ovr = 0;
            exp_mis = 0;
            if (address_ready && (is_load || is_store)) begin
                if (busy_e) begin
                    exp_ovr = 1;
                end else if (f_mis(mem_op, addr_in[1:0])) begin
                    exp_mis = 1;
                    if (is_load) begin
                        m_act = 1; m_load = 1; m_bus = 0; m_a = cyc;
                        m_d = cyc + 1; m_s = cyc + 9; m_word = '0;
                    end
                end else begin
                    m_act = 1; m_load = is_load; m_bus = 1; m_a = cyc; m_d = -1;
                    m_op = mem_op; m_off = addr_in[1:0]; m_addr = addr_in[27:2];
                    m_wdata = f_wdata(mem_op, drv_data);
                    m_wstrb = f_wstrb(mem_op, addr_in[1:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Serialise data LS nibble first over counts 0..7, with address_ready on count 7.
    task automatic issue(input bit ld, input bit st, input logic [2:0] op,
                         input logic [27:0] addr, input logic [31:0] data);
        drv_data = data;
        while (counter != 3'd0) step();
        for (int i = 0; i < 8; i++) begin
            store_nibble  = data[4 * i +: 4];
            address_ready = (i == 7);
            is_load       = ld && (i == 7);
            is_store      = st && (i == 7);
            mem_op        = op;
            addr_in       = addr;
            step();
        end
        address_ready = 1'b0;
        is_load       = 1'b0;
        is_store      = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check("idle_reached", busy, 1'b0);
        step();
    endtask

    int w0, s0, o0, r0, m0;

    initial begin
        #1 rstn = 1'b0;
        repeat (3) step();
        check("reset_busy", busy, 1'b0);
        check("reset_ldr", load_data_ready, 1'b0);
        rstn = 1'b1;
        step();

        // SW, zero-wait bus with mem_ready tied high
        tie_ready = 1'b1;
        w0 = wr_n;
        issue(1'b0, 1'b1, 3'b010, 28'h0000104, 32'hDEADBEEF);
        wait_idle();
        check("sw_write_cycles", wr_n - w0, 1);
        check("sw_addr", last_addr, 26'h41);
        check("sw_wstrb", last_wstrb, 4'b1111);
        check("sw_wdata", last_wdata, 32'hDEADBEEF);
        tie_ready = 1'b0;

        // SB to byte 3
        issue(1'b0, 1'b1, 3'b000, 28'h0000007, 32'h000000A5);
        wait_idle();
        check("sb_addr", last_addr, 26'h1);
        check("sb_wstrb", last_wstrb, 4'b1000);
        check("sb_wdata", last_wdata, 32'hA5A5A5A5);

        // SH to upper half
        issue(1'b0, 1'b1, 3'b001, 28'h0000002, 32'h1234BEEF);
        wait_idle();
        check("sh_wstrb", last_wstrb, 4'b1100);
        check("sh_wdata", last_wdata, 32'hBEEFBEEF);

        // LB byte 3, bus answers after 5 cycles
        ready_delay = 5;
        mem_rdata = 32'h80112233;
        s0 = stream_n;
        first_cnt = -1;
        issue(1'b1, 1'b0, 3'b000, 28'h0000003, 32'h0);
        wait_idle();
        check("lb_stream_len", stream_n - s0, 8);
        check("lb_first_count", first_cnt, 0);
        check("lb_word", stream_word, 32'hFFFFFF80);

        // LHU upper half
        ready_delay = 0;
        mem_rdata = 32'h89AB0000;
        o0 = ovr_n;
        issue(1'b1, 1'b0, 3'b101, 28'h0000002, 32'h0);
        wait_idle();
        check("lhu_word", stream_word, 32'h000089AB);
        check("lhu_no_overrun", ovr_n - o0, 0);

        // LH sign extension, LBU zero extension
        mem_rdata = 32'h12348001;
        issue(1'b1, 1'b0, 3'b001, 28'h0000000, 32'h0);
        wait_idle();
        check("lh_word", stream_word, 32'hFFFF8001);
        mem_rdata = 32'h0000F000;
        issue(1'b1, 1'b0, 3'b100, 28'h0000001, 32'h0);
        wait_idle();
        check("lbu_word", stream_word, 32'h000000F0);

        // address_ready with neither load nor store is ignored
        issue(1'b0, 1'b0, 3'b010, 28'h0000040, 32'h0);
        step();
        check("ignored_busy", busy, 1'b0);

        // Second request while LW pending: overrun, first read completes
        ready_delay = 1000;
        mem_rdata = 32'h12345678;
        o0 = ovr_n;
        issue(1'b1, 1'b0, 3'b010, 28'h0000010, 32'h0);
        issue(1'b1, 1'b0, 3'b010, 28'h0000020, 32'h0);
        ready_delay = 2;
        wait_idle();
        check("overrun_pulses", ovr_n - o0, 1);
        check("overrun_word", stream_word, 32'h12345678);

        // Reset while mem_read is high
        ready_delay = 1000;
        issue(1'b1, 1'b0, 3'b010, 28'h0000030, 32'h0);
        step();
        check("pre_reset_read", mem_read, 1'b1);
        #1 rstn = 1'b0;
        #1;
        check("async_reset_read", mem_read, 1'b0);
        check("async_reset_busy", busy, 1'b0);
        step();
        step();
        rstn = 1'b1;
        ready_delay = 0;
        step();

`ifdef TINY45_MEMCTL_ALIGN_CHECK_EN
        // Misaligned LW: no bus request, error pulse, zero word streamed
        mem_rdata = 32'hFFFFFFFF;
        m0 = mis_n;
        r0 = rd_n;
        issue(1'b1, 1'b0, 3'b010, 28'h0000002, 32'h0);
        wait_idle();
        check("mis_pulse", mis_n - m0, 1);
        check("mis_no_read", rd_n - r0, 0);
        check("mis_word", stream_word, 32'h0);
`endif

        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
